// File: rtl/d_axi_pkg.sv
// Shared types and constants for the sram-like to AXI bridge: FSM state
// encoding, fixed AXI attribute values and the core's access-size codes.
package d_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_RD_ADDR      = 3'd1,
        ST_RD_DATA      = 3'd2,
        ST_WR_ADDR_DATA = 3'd3,
        ST_WR_RESP      = 3'd4
    } state_e;

    localparam logic [3:0] AXI_ID_DEFAULT = 4'd1;
    localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_LOCK_NONE  = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONE = 4'b0000;
    localparam logic [2:0] AXI_PROT_NONE  = 3'b000;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/d_axi_bridge_wstrb_gen.sv
// Byte-lane strobe generation from access size and the low address bits.
module wstrb_gen
    import d_axi_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_wstrb
);

    // Lane mask per access size; the reserved size code enables no lanes.
    always_comb begin
        o_wstrb = 4'b0000;
        case (i_size)
            SIZE_BYTE: o_wstrb = 4'b0001 << i_addr_lo;
            SIZE_HALF: o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
            SIZE_WORD: o_wstrb = 4'b1111;
            default:   o_wstrb = 4'b0000;
        endcase
    end

endmodule

// File: rtl/d_axi_bridge.sv
// Single-outstanding bridge from the core's sram-like data port to an AXI3
// master interface; one request is accepted only while the FSM is idle.
module d_axi_bridge
    import d_axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = AXI_ID_DEFAULT
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    state_e      r_state;
    state_e      w_next_state;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_aw_done;
    logic        r_w_done;
    logic [3:0]  w_wstrb;
    logic        w_unused;

    // Response status and ids are deliberately ignored.
    assign w_unused = &{1'b0, rid, rresp, rlast, bid, bresp};

    wstrb_gen u_wstrb_gen (
        .i_size    (data_size),
        .i_addr_lo (data_addr[1:0]),
        .o_wstrb   (w_wstrb)
    );

    assign arid    = AXI_ID;
    assign arlen   = AXI_LEN_SINGLE;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = AXI_LOCK_NONE;
    assign arcache = AXI_CACHE_NONE;
    assign arprot  = AXI_PROT_NONE;
    assign araddr  = r_addr;
    assign arsize  = {1'b0, r_size};

    assign awid    = AXI_ID;
    assign awlen   = AXI_LEN_SINGLE;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = AXI_LOCK_NONE;
    assign awcache = AXI_CACHE_NONE;
    assign awprot  = AXI_PROT_NONE;
    assign awaddr  = r_addr;
    assign awsize  = {1'b0, r_size};

    assign wid        = AXI_ID;
    assign wdata      = r_wdata;
    assign wstrb      = r_wstrb;
    assign wlast      = 1'b1;
    assign data_rdata = rdata;

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request capture on acceptance; in-flight fields ignore later core input changes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr  <= 32'h0000_0000;
            r_size  <= 2'd0;
            r_wdata <= 32'h0000_0000;
            r_wstrb <= 4'b0000;
        end else if (data_addr_ok) begin
            r_addr  <= data_addr;
            r_size  <= data_size;
            r_wdata <= data_wdata;
            r_wstrb <= w_wstrb;
        end else begin
            r_addr  <= r_addr;
            r_size  <= r_size;
            r_wdata <= r_wdata;
            r_wstrb <= r_wstrb;
        end
    end

    // AW and W complete independently; each flag remembers its own handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (data_addr_ok) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_aw_done <= r_aw_done | (awvalid & awready);
            r_w_done  <= r_w_done  | (wvalid  & wready);
        end
    end

    // Next-state and channel handshake outputs.
    always_comb begin
        w_next_state = r_state;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                data_addr_ok = data_req & resetn;
                if (data_addr_ok) begin
                    w_next_state = data_wr ? ST_WR_ADDR_DATA : ST_RD_ADDR;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    w_next_state = ST_RD_DATA;
                end else begin
                    w_next_state = ST_RD_ADDR;
                end
            end
            ST_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    data_data_ok = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RD_DATA;
                end
            end
            ST_WR_ADDR_DATA: begin
                awvalid = ~r_aw_done;
                wvalid  = ~r_w_done;
                if ((r_aw_done | awready) & (r_w_done | wready)) begin
                    w_next_state = ST_WR_RESP;
                end else begin
                    w_next_state = ST_WR_ADDR_DATA;
                end
            end
            ST_WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    data_data_ok = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_WR_RESP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/d_axi_bridge.md
D_AXI_BRIDGE -- requirements
Module: d_axi_bridge

Interface
REQ-001 Parameter AXI_ID, default 4'd1: constant value driven on arid, awid and wid.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 data_req  input  1  sram-like request valid, from core after address translation.
REQ-005 data_wr  input  1  1 = write, 0 = read.
REQ-006 data_size  input  2  0 = byte, 1 = halfword, 2 = word.
REQ-007 data_addr  input  32  physical address, already translated.
REQ-008 data_wdata  input  32  write data, lane-aligned by the core.
REQ-009 data_addr_ok  output  1  request accepted this cycle.
REQ-010 data_data_ok  output  1  transaction complete this cycle.
REQ-011 data_rdata  output  32  read data, valid when data_data_ok is high for a read.
REQ-012 AR channel  output  araddr 32, arsize 3, arvalid 1, plus constants arid/arlen/arburst/arlock/arcache/arprot; input arready 1.
REQ-013 R channel  input  rid 4, rdata 32, rresp 2, rlast 1, rvalid 1; output rready 1.
REQ-014 AW channel  output  awaddr 32, awsize 3, awvalid 1, plus constants; input awready 1.
REQ-015 W channel  output  wdata 32, wstrb 4, wlast 1, wvalid 1, wid 4; input wready 1.
REQ-016 B channel  input  bid 4, bresp 2, bvalid 1; output bready 1.

Function
REQ-017 Constants: arlen/awlen = 0, arburst/awburst = 2'b01, lock = 0, cache = 4'b0000, prot = 3'b000, wlast = 1.
REQ-018 FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP; only one transaction is outstanding at a time.
REQ-019 data_addr_ok = (state == IDLE) & data_req, combinational; the request is accepted on that cycle.
REQ-020 On acceptance, addr, size, wr, wdata and the generated wstrb are latched; the FSM moves to RD_ADDR if wr = 0, otherwise to WR_ADDR_DATA.
REQ-021 RD_ADDR: arvalid = 1, araddr = latched addr, arsize = {1'b0, size}; on arvalid & arready the FSM moves to RD_DATA.
REQ-022 RD_DATA: rready = 1; on rvalid the FSM moves to IDLE; data_data_ok = 1 and data_rdata = rdata in that same cycle.
REQ-023 WR_ADDR_DATA: awvalid and wvalid start at 1; each drops independently after its own handshake; the FSM moves to WR_RESP once both have completed, including the case where both complete in the same cycle.
REQ-024 WR_RESP: bready = 1; on bvalid, data_data_ok = 1 and the FSM moves to IDLE.
REQ-025 wstrb: byte = 4'b0001 << addr[1:0]; halfword = 4'b0011 << {addr[1],1'b0}; word = 4'b1111; size 3 = 4'b0000.
REQ-026 wdata is passed through unchanged; the core performs lane alignment.
REQ-027 rresp, bresp and id fields are ignored; error responses complete normally.
REQ-028 data_data_ok is high for exactly one cycle per accepted request; data_addr_ok is never high in the same cycle as data_data_ok.
REQ-029 A request held high after completion is accepted again no earlier than the cycle after data_data_ok.
REQ-030 Changes to the data_* inputs while busy have no effect on the in-flight transaction.

Reset
REQ-031 When resetn is low, the FSM enters IDLE and all valid, ready, data_addr_ok and data_data_ok outputs are 0; latched address, data and wstrb are 0.
REQ-032 Reset asserted mid-transaction abandons that transaction; no data_data_ok is generated for it after reset is released.

Structure
REQ-033 Package d_axi_pkg holds the state enum, the AXI_ID default, the burst/len/cache/prot constants and the size encodings.
REQ-034 The single sub-module wstrb_gen (combinational: size, addr[1:0] -> wstrb) implements REQ-025.

Verification
REQ-035 Word read: req=1, wr=0, size=2, addr=0x1FC00004 -> addr_ok in the same cycle; next cycle arvalid=1, araddr=0x1FC00004, arsize=2; rvalid with rdata=0xDEADBEEF -> data_ok=1 and data_rdata=0xDEADBEEF for one cycle.
REQ-036 Byte write: size=0, addr=0x00000013, wdata=0x000000AB -> awsize=0, wstrb=4'b1000, wdata=0x000000AB; bvalid -> one data_ok pulse.
REQ-037 Skewed write handshake: wready=1 immediately, awready delayed 3 cycles -> wvalid drops after 1 cycle, awvalid held 4 cycles, bready asserted only after both handshakes.
REQ-038 Back-to-back requests: req held high for two reads -> second addr_ok occurs exactly one cycle after the first data_ok; exactly two data_ok pulses.
REQ-039 Halfword write at addr[1:0]=2 -> wstrb=4'b1100; word write -> wstrb=4'b1111.
REQ-040 Reset while in RD_DATA -> all valid and ready outputs 0 immediately; no data_ok after release; next request accepted from IDLE.
